// File: rtl/mont_mul_serial_if.sv
// Start/operand/result bundle for the bit-serial Montgomery multiplier.
// The master side issues jobs and the slave side is the multiplier.
interface mont_mul_serial_if #(
  parameter int DW = 32
);
  logic          in_sig;
  logic [DW-1:0] a_i;
  logic [DW-1:0] b_i;
  logic [DW-1:0] prime_i;
  logic [DW-1:0] result;
  logic          busy;
  logic          done;

  modport master (
    output in_sig, a_i, b_i, prime_i,
    input  result, busy, done
  );

  modport slave (
    input  in_sig, a_i, b_i, prime_i,
    output result, busy, done
  );
endinterface

// File: rtl/mont_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-DW mod prime,
// one multiplier bit per cycle followed by a single conditional subtraction.
//
// state | meaning
// IDLE  | waiting for in_sig; operands latched on accept
// CALC  | DW iterations, one bit of a_reg per cycle
// FINAL | conditional subtraction into result, done pulses next cycle
module mont_mul_serial #(
  parameter int DW = 32,
  parameter int CW = 5
) (
  input  logic               clk,
  input  logic               reset,
  mont_mul_serial_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

  state_t        state, state_nxt;
  logic [DW+1:0] s, s_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] a_reg, a_nxt;
  logic [DW-1:0] b_reg, b_nxt;
  logic [DW-1:0] p_reg, p_nxt;
  logic [DW-1:0] result_q, result_nxt;
  logic          done_q, done_nxt;
  logic [DW+1:0] t_add, t_odd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      s        <= '0;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      p_reg    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      s        <= s_nxt;
      cnt      <= cnt_nxt;
      a_reg    <= a_nxt;
      b_reg    <= b_nxt;
      p_reg    <= p_nxt;
      result_q <= result_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    s_nxt      = s;
    cnt_nxt    = cnt;
    a_nxt      = a_reg;
    b_nxt      = b_reg;
    p_nxt      = p_reg;
    result_nxt = result_q;
    done_nxt   = 1'b0;
    // S < 2p keeps S + b + p below 4p, so DW+2 bits never overflow
    t_add      = s + (a_reg[cnt] ? {2'b00, b_reg} : '0);
    t_odd      = t_add[0] ? t_add + {2'b00, p_reg} : t_add;

    case (state)
      IDLE: begin
        if (bus.in_sig) begin
          a_nxt     = bus.a_i;
          b_nxt     = bus.b_i;
          p_nxt     = bus.prime_i;
          s_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = CALC;
        end
      end
      CALC: begin
        s_nxt   = t_odd >> 1;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(DW - 1)) state_nxt = FINAL;
      end
      FINAL: begin
        // the true difference is below p, so DW-bit wraparound is exact
        if (s >= {2'b00, p_reg}) result_nxt = s[DW-1:0] - p_reg;
        else                     result_nxt = s[DW-1:0];
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.result = result_q;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;

endmodule

// File: doc/mont_mul_serial.md
Name: mont_mul_serial

Overview:
- Bit-serial radix-2 Montgomery modular multiplier for the ECC datapath.
- Sits directly downstream of the domain-transfer stage and consumes its Montgomery-domain operands (R = 2^32).
- Computes result = a·b·R^-1 mod prime, one multiplier bit per cycle, with a single final conditional subtraction.
- Point add/double control issues one multiply per start pulse and waits for done.

Parameters:
- DW, 32, operand/prime width in bits; R = 2^DW; iteration count = DW
- CW, 5, counter width; must satisfy 2^CW ≥ DW

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_sig  input  1  start pulse; sampled only in IDLE
- a_i  input  DW  multiplicand (Montgomery domain), must be < prime_i
- b_i  input  DW  multiplier (Montgomery domain), must be < prime_i
- prime_i  input  DW  modulus, odd, ≥ 3
- result  output  DW  a·b·2^-DW mod prime; registered; held until next accepted start
- busy  output  1  high in CALC and FINAL
- done  output  1  one-cycle pulse when result is updated

Behaviour:
- Reset (reset=1 at clk edge) takes priority over everything. State goes to IDLE; S, counter, latched operands, result, busy and done all go to 0. Applies mid-operation; the aborted job produces no done.
- Datapath: accumulator S is DW+2 bits wide. Invariant S < 2·prime after every iteration; intermediates S + b + prime < 4·prime fit in DW+2 bits without truncation.
- IDLE:
  - busy=0.
  - in_sig=1 latches a_i, b_i, prime_i into internal registers, clears S and counter, and moves to CALC.
  - Input changes after the accept cycle have no effect on the running job.
- CALC, iteration i = counter, 0..DW-1:
  - T = S + (a_reg[i] ? b_reg : 0)
  - If T[0]=1: T = T + prime_reg
  - S_next = T >> 1
  - counter increments each cycle.
  - After iteration DW-1, go to FINAL. Exactly DW cycles are spent in CALC.
- FINAL (1 cycle):
  - If S ≥ prime_reg, result ← S − prime_reg; else result ← S (low DW bits).
  - done=1 on the following cycle; go to IDLE.
- Latency: in_sig accepted at edge E0; done=1 and the new result are visible in the cycle after edge E0 + DW + 1 (34 cycles for DW=32).
- done:
  - High for exactly one cycle, coincident with the first cycle result holds the new value. busy=0 in that cycle.
  - in_sig in that same cycle is accepted (back-to-back operation allowed).
- in_sig while busy=1 is ignored; no queuing, no error flag.
- Operands with a ≥ prime, b ≥ prime, or even prime are outside the contract. Result is unspecified, but the FSM must still complete and pulse done.
- Idempotence: a = R mod p yields result = b (domain-preserving multiply by one).

Test Plan:
- prime=13, a=9 (R mod 13), b=5, pulse in_sig → done after 34 cycles, result=5.
- prime=13, a=1, b=1 → result=3 (2^-32 mod 13).
- prime=0xFFFFFFFB, a=b=0xFFFFFFFA → result=0xCCCCCCC9. Exercises the full DW+2-bit accumulator and the final subtraction.
- prime=13, a=0, b=7 → result=0. Then pulse in_sig on the done cycle with a=9, b=7 → second done exactly 34 cycles later, result=7.
- Start a job, toggle in_sig and change a_i/b_i at cycle 10 → ignored; result matches the originally latched operands.
- Start a job, assert reset at cycle 15 → next cycle busy=0, done=0, result=0. No done pulse ever appears for the aborted job. A fresh start then completes normally.
